simd_operand_stager: RTL and testbench
======================================

SIMD_OPERAND_STAGER -- requirements
Module: simd_operand_stager

Interface
REQ-001 SHALL have parameter DATA_W, default 64: width of each assembled operand; the downstream SIMD adder operates on 16 lanes of 4 bits.
REQ-002 SHALL have parameter BEAT_W, default 16: width of one input beat; DATA_W SHALL be an integer multiple of BEAT_W; BEATS = DATA_W/BEAT_W.
REQ-003 SHALL use a single clock; reset is asynchronous and active-high.
REQ-004 SHALL have ports, one per line: name  direction  width  meaning.
- clk  in  1  sole clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous abort of the operand being assembled.
- in_valid  in  1  input beat valid.
- in_ready  out  1  stager can accept a beat.
- in_data  in  BEAT_W  operand beat.
- in_conf  in  4  adder conf {en,sub,rsv,rsv}; sampled on beat 0 only.
- op_valid  out  1  operand pair ready for the adder.
- op_ready  in  1  adder side accepts the pair.
- op_a  out  DATA_W  operand A.
- op_b  out  DATA_W  operand B.
- op_conf  out  4  conf for the pair.
- busy  out  1  at least one beat of the current pair is held.

Function
REQ-005 SHALL implement a three-state FSM: LOAD_A, LOAD_B and HOLD, plus a beat counter of width clog2(BEATS).
REQ-006 A beat SHALL transfer only in a cycle where in_valid and in_ready are both 1.
REQ-007 in_ready SHALL be 1 in LOAD_A and LOAD_B and 0 in HOLD; it SHALL depend only on registered state.
REQ-008 In LOAD_A, beat k SHALL be written to op_a[k*BEAT_W +: BEAT_W], least-significant beat first.
REQ-009 In LOAD_A, in_conf SHALL be captured into op_conf on beat 0.
REQ-010 On beat BEATS-1 in LOAD_A, the FSM SHALL go to LOAD_B and the counter SHALL wrap to 0.
REQ-011 In LOAD_B, beats SHALL fill op_b in the same order; on beat BEATS-1 the FSM SHALL go to HOLD.
REQ-012 op_valid SHALL equal (state==HOLD) and SHALL be registered.
REQ-013 Latency: op_valid SHALL assert in the cycle after the final B beat transfers.
REQ-014 op_a, op_b and op_conf SHALL remain stable while op_valid=1.
REQ-015 Minimum period SHALL be 2*BEATS+1 cycles per pair.
REQ-016 On op_valid && op_ready, the FSM SHALL go to LOAD_A with counter 0.
REQ-017 No beat SHALL be accepted in the cycle op_ready is seen, so there is no combinational path from op_ready to in_ready.
REQ-018 A stalled op_ready SHALL hold HOLD indefinitely and SHALL not lose data.
REQ-019 flush=1 SHALL force LOAD_A, counter 0, and op_a/op_b/op_conf to 0, in any state.
REQ-020 flush SHALL take priority over a beat transfer or an output handshake in the same cycle; that beat or pair is discarded.
REQ-021 busy SHALL be 1 unless state==LOAD_A and counter==0.
REQ-022 in_valid asserted while in_ready=0 SHALL be ignored; the source holds data until accepted.

Reset
REQ-023 rst SHALL immediately set state=LOAD_A, counter=0, op_a=0, op_b=0 and op_conf=0.
REQ-024 While in reset, outputs SHALL be op_valid=0, busy=0 and in_ready=1.
REQ-025 Reset asserted mid-assembly or in HOLD SHALL discard all partial or held data, with no output handshake.

Structure
REQ-026 A shared package SHALL hold the FSM state enum, the conf bit positions (CONF_EN=3, CONF_SUB=2) and default DATA_W/BEAT_W.
REQ-027 SHALL be a single module with no sub-module; it connects op_a/op_b/op_conf directly to the SIMD adder's A/B/conf.

Verification
REQ-028 The bench SHALL cover the following directed scenarios.
- Basic pair: beats 0x3210,0x7654,0xBA98,0xFEDC then 0x1111 x4, conf=0x8, op_ready=1 -> op_a=0xFEDCBA9876543210, op_b=0x1111111111111111, op_conf=0x8, op_valid for 1 cycle, exactly 1 cycle after the 8th beat.
- Back-pressure: op_ready=0 for 20 cycles in HOLD -> in_ready=0, outputs stable, op_valid held; op_ready=1 -> return to LOAD_A next cycle.
- Gapped input: in_valid toggled 1/0 each cycle -> same assembled values as the basic pair; counter advances only on handshakes.
- Conf sampling: in_conf=0xC on beat 0 and 0x0 on later beats -> op_conf=0xC.
- Flush: flush on A beat 2 -> busy=0 next cycle; a fresh 8-beat pair is then assembled correctly. Flush coincident with op_ready in HOLD -> op_valid drops and no second pair is presented.
- Async reset mid LOAD_B -> outputs zero immediately, without waiting for a clock edge; the next 8 beats form a correct pair.

Source files
------------

// File: rtl/simd_operand_stager_pkg.sv
// Shared definitions for the SIMD operand stager: FSM states, adder conf bit
// positions and the default operand/beat widths.
package simd_operand_stager_pkg;

  typedef enum logic [1:0] {
    LOAD_A = 2'd0,
    LOAD_B = 2'd1,
    HOLD   = 2'd2
  } stager_state_t;

  // Bit positions inside the 4-bit adder conf word {en,sub,rsv,rsv}
  localparam int CONF_EN  = 3;
  localparam int CONF_SUB = 2;

  localparam int DEFAULT_DATA_W = 64;
  localparam int DEFAULT_BEAT_W = 16;

endpackage

// File: rtl/simd_operand_stager.sv
// Assembles operand A then operand B from narrow input beats and presents the
// pair, together with the conf word captured on A's first beat, to the SIMD adder.
module simd_operand_stager
  import simd_operand_stager_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int BEAT_W = DEFAULT_BEAT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [BEAT_W-1:0] in_data,
  input  logic [3:0]        in_conf,
  output logic              op_valid,
  input  logic              op_ready,
  output logic [DATA_W-1:0] op_a,
  output logic [DATA_W-1:0] op_b,
  output logic [3:0]        op_conf,
  output logic              busy
);

  localparam int BEATS = DATA_W / BEAT_W;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  stager_state_t    state, state_next;
  logic [CNT_W-1:0] beat_cnt, beat_cnt_next;
  logic             beat_xfer;
  logic             pair_fire;
  int unsigned      beat_base;

  // in_ready decodes registered state only, so op_ready never reaches it
  assign in_ready  = (state != HOLD);
  assign beat_xfer = in_valid && in_ready;
  assign pair_fire = op_valid && op_ready;
  assign busy      = !((state == LOAD_A) && (beat_cnt == '0));
  assign beat_base = int'(beat_cnt) * BEAT_W;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= LOAD_A;
      beat_cnt <= '0;
      op_valid <= 1'b0;
    end else begin
      state    <= state_next;
      beat_cnt <= beat_cnt_next;
      op_valid <= (state_next == HOLD);
    end
  end

  always_comb begin
    state_next    = state;
    beat_cnt_next = beat_cnt;
    if (flush) begin
      state_next    = LOAD_A;
      beat_cnt_next = '0;
    end else begin
      case (state)
        LOAD_A: begin
          if (beat_xfer) begin
            if (beat_cnt == LAST_BEAT) begin
              state_next    = LOAD_B;
              beat_cnt_next = '0;
            end else begin
              beat_cnt_next = beat_cnt + 1'b1;
            end
          end
        end
        LOAD_B: begin
          if (beat_xfer) begin
            if (beat_cnt == LAST_BEAT) begin
              state_next    = HOLD;
              beat_cnt_next = '0;
            end else begin
              beat_cnt_next = beat_cnt + 1'b1;
            end
          end
        end
        HOLD: begin
          if (pair_fire) begin
            state_next    = LOAD_A;
            beat_cnt_next = '0;
          end
        end
        default: begin
          state_next    = LOAD_A;
          beat_cnt_next = '0;
        end
      endcase
    end
  end

  // Operand registers only change on an accepted beat, so they hold in HOLD
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_a    <= '0;
      op_b    <= '0;
      op_conf <= '0;
    end else if (flush) begin
      op_a    <= '0;
      op_b    <= '0;
      op_conf <= '0;
    end else if (beat_xfer) begin
      case (state)
        LOAD_A: begin
          op_a[beat_base +: BEAT_W] <= in_data;
          if (beat_cnt == '0) begin
            op_conf <= in_conf;
          end
        end
        LOAD_B: op_b[beat_base +: BEAT_W] <= in_data;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_simd_operand_stager.sv
// Self-checking bench for simd_operand_stager: directed scenarios plus random
// traffic compared every cycle against a beat-queue reference model.
module tb_simd_operand_stager;

  localparam int DATA_W = 64;
  localparam int BEAT_W = 16;
  localparam int BEATS  = DATA_W / BEAT_W;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              flush = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [BEAT_W-1:0] in_data = '0;
  logic [3:0]        in_conf = '0;
  logic              op_valid;
  logic              op_ready = 1'b0;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic [3:0]        op_conf;
  logic              busy;

  int checks = 0;
  int errors = 0;

  simd_operand_stager #(.DATA_W(DATA_W), .BEAT_W(BEAT_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_conf(in_conf),
    .op_valid(op_valid), .op_ready(op_ready),
    .op_a(op_a), .op_b(op_b), .op_conf(op_conf), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: the list of beats accepted for the current pair
  logic [BEAT_W-1:0] m_beats[$];
  logic [3:0]        m_conf = '0;
  bit                m_hold = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst || flush) begin
      m_beats.delete();
      m_conf = '0;
      m_hold = 1'b0;
    end else if (m_hold) begin
      if (op_ready) begin
        m_beats.delete();
        m_hold = 1'b0;
      end
    end else if (in_valid) begin
      if (m_beats.size() == 0) m_conf = in_conf;
      m_beats.push_back(in_data);
      if (m_beats.size() == 2 * BEATS) m_hold = 1'b1;
    end
  end

  function automatic logic [63:0] model_operand(input int first);
    logic [63:0] v = '0;
    for (int k = 0; k < BEATS; k++) v[k*BEAT_W +: BEAT_W] = m_beats[first + k];
    return v;
  endfunction

  always @(negedge clk) begin
    check_output("in_ready", 64'(in_ready), 64'(!m_hold));
    check_output("op_valid", 64'(op_valid), 64'(m_hold));
    check_output("busy", 64'(busy), 64'(m_hold || (m_beats.size() != 0)));
    if (m_hold) begin
      check_output("model_op_a", op_a, model_operand(0));
      check_output("model_op_b", op_b, model_operand(BEATS));
      check_output("model_op_conf", 64'(op_conf), 64'(m_conf));
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [BEAT_W-1:0] d, input logic [3:0] c);
    bit done = 1'b0;
    int guard = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_conf  = c;
    while (!done && guard < 50) begin
      done = in_ready;
      next_cycle();
      guard++;
    end
    in_valid = 1'b0;
    if (!done) check_output("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic apply_stimulus(input logic [63:0] a, input logic [63:0] b,
                                input logic [3:0] conf0, input logic [3:0] conf_rest,
                                input bit gapped);
    for (int k = 0; k < 2 * BEATS; k++) begin
      send_beat((k < BEATS) ? a[k*BEAT_W +: BEAT_W] : b[(k-BEATS)*BEAT_W +: BEAT_W],
                (k == 0) ? conf0 : conf_rest);
      if (gapped && k < 2 * BEATS - 1) next_cycle();
    end
  endtask

  task automatic check_pair(input string tag, input logic [63:0] a, input logic [63:0] b,
                            input logic [3:0] c);
    check_output({tag, "_valid"}, 64'(op_valid), 64'd1);
    check_output({tag, "_op_a"}, op_a, a);
    check_output({tag, "_op_b"}, op_b, b);
    check_output({tag, "_op_conf"}, 64'(op_conf), 64'(c));
  endtask

  localparam logic [63:0] A0 = 64'hFEDCBA9876543210;
  localparam logic [63:0] B0 = 64'h1111111111111111;
  localparam logic [63:0] A1 = 64'h0123456789ABCDEF;
  localparam logic [63:0] B1 = 64'hCAFEBABEDEADBEEF;

  initial begin
    repeat (3) next_cycle();
    check_output("reset_op_valid", 64'(op_valid), 64'd0);
    check_output("reset_busy", 64'(busy), 64'd0);
    check_output("reset_in_ready", 64'(in_ready), 64'd1);
    check_output("reset_op_a", op_a, 64'd0);
    rst = 1'b0;
    next_cycle();

    // Basic pair: op_valid exactly one cycle after the 8th beat, for one cycle
    op_ready = 1'b1;
    apply_stimulus(A0, B0, 4'h8, 4'h8, 1'b0);
    check_pair("basic", A0, B0, 4'h8);
    next_cycle();
    check_output("basic_valid_drop", 64'(op_valid), 64'd0);
    check_output("basic_ready_back", 64'(in_ready), 64'd1);

    // Gapped input
    apply_stimulus(A0, B0, 4'h8, 4'h8, 1'b1);
    check_pair("gapped", A0, B0, 4'h8);
    next_cycle();

    // Back-pressure with an ignored in_valid during HOLD
    op_ready = 1'b0;
    apply_stimulus(A1, B1, 4'h4, 4'h4, 1'b0);
    in_valid = 1'b1;
    in_data  = 16'hFFFF;
    for (int i = 0; i < 20; i++) begin
      check_output("bp_valid", 64'(op_valid), 64'd1);
      check_output("bp_in_ready", 64'(in_ready), 64'd0);
      check_output("bp_op_a", op_a, A1);
      check_output("bp_op_b", op_b, B1);
      next_cycle();
    end
    in_valid = 1'b0;
    op_ready = 1'b1;
    next_cycle();
    check_output("bp_release_valid", 64'(op_valid), 64'd0);
    check_output("bp_release_busy", 64'(busy), 64'd0);

    // Conf sampled on beat 0 only
    op_ready = 1'b0;
    apply_stimulus(A1, B0, 4'hC, 4'h0, 1'b0);
    check_pair("conf", A1, B0, 4'hC);
    op_ready = 1'b1;
    next_cycle();

    // Flush on A beat 2, then a fresh pair
    send_beat(16'hAAAA, 4'h8);
    send_beat(16'hBBBB, 4'h8);
    in_valid = 1'b1;
    in_data  = 16'hCCCC;
    flush    = 1'b1;
    next_cycle();
    flush    = 1'b0;
    in_valid = 1'b0;
    check_output("flush_busy", 64'(busy), 64'd0);
    check_output("flush_op_a", op_a, 64'd0);
    check_output("flush_op_conf", 64'(op_conf), 64'd0);
    apply_stimulus(A0, B1, 4'h8, 4'h0, 1'b0);
    check_pair("post_flush", A0, B1, 4'h8);
    next_cycle();

    // Flush coincident with op_ready in HOLD
    op_ready = 1'b0;
    apply_stimulus(A1, B0, 4'h4, 4'h4, 1'b0);
    check_output("hold_flush_pre", 64'(op_valid), 64'd1);
    op_ready = 1'b1;
    flush    = 1'b1;
    next_cycle();
    flush = 1'b0;
    check_output("hold_flush_op_b", op_b, 64'd0);
    for (int i = 0; i < 5; i++) begin
      check_output("hold_flush_valid", 64'(op_valid), 64'd0);
      next_cycle();
    end

    // Asynchronous reset mid LOAD_B, checked between clock edges
    for (int k = 0; k < BEATS + 2; k++) send_beat(16'h5A5A, 4'h8);
    #3;
    rst = 1'b1;
    #1;
    check_output("areset_op_a", op_a, 64'd0);
    check_output("areset_op_b", op_b, 64'd0);
    check_output("areset_op_conf", 64'(op_conf), 64'd0);
    check_output("areset_valid", 64'(op_valid), 64'd0);
    check_output("areset_busy", 64'(busy), 64'd0);
    check_output("areset_in_ready", 64'(in_ready), 64'd1);
    #2;
    rst = 1'b0;
    next_cycle();
    apply_stimulus(A0, B0, 4'h8, 4'h8, 1'b0);
    check_pair("post_reset", A0, B0, 4'h8);
    next_cycle();

    // Random traffic checked by the model every cycle
    for (int i = 0; i < 2000; i++) begin
      flush    = ($urandom_range(0, 59) == 0);
      in_valid = 1'($urandom_range(0, 1));
      in_data  = 16'($urandom);
      in_conf  = 4'($urandom);
      op_ready = ($urandom_range(0, 3) != 0);
      next_cycle();
    end
    flush    = 1'b0;
    in_valid = 1'b0;
    op_ready = 1'b1;
    repeat (3) next_cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
